// File: rtl/sequenciador_servo_base.sv
// Base servo sequencer: accepts one rotation command at a time,
// drives the position code and waits a distance-scaled settle time.
module sequenciador_servo_base #(
    parameter int ESPERA_90     = 25000000,
    parameter int ESPERA_180    = 45000000,
    parameter int CONTADOR_BITS = 26
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [1:0] comando,
    output logic [1:0] posicao,
    output logic       ocupado,
    output logic       pronto,
    output logic       erro,
    output logic [2:0] db_estado,
    output logic [1:0] db_posicao
);

    localparam logic [2:0] OCIOSO = 3'd0;
    localparam logic [2:0] ESPERA = 3'd1;
    localparam logic [2:0] FIM    = 3'd2;
    localparam logic [2:0] ERRO   = 3'd3;

    localparam logic [1:0] NEUTRO = 2'b01;

    // Counter reload values: the wait lasts T cycles, counting T-1 down to 0.
    localparam logic [CONTADOR_BITS-1:0] CARGA_90 =
        CONTADOR_BITS'(ESPERA_90 - 1);
    localparam logic [CONTADOR_BITS-1:0] CARGA_180 =
        CONTADOR_BITS'(ESPERA_180 - 1);

    logic [2:0]               estado_q, estado_d;
    logic [1:0]               posicao_q, posicao_d;
    logic [CONTADOR_BITS-1:0] contador_q, contador_d;

    logic dist_zero;
    logic dist_dois;

    // Rotation distance between the requested and the current position.
    always_comb begin
        dist_zero = (comando == posicao_q);
        dist_dois = ((comando ^ posicao_q) == 2'b10);
    end

    // Next-state, target and settle counter selection.
    always_comb begin
        estado_d   = estado_q;
        posicao_d  = posicao_q;
        contador_d = contador_q;
        case (estado_q)
            OCIOSO: begin
                if (iniciar) begin
                    if (comando == 2'b11) begin
                        estado_d = ERRO;
                    end else if (dist_zero) begin
                        estado_d = FIM;
                    end else begin
                        estado_d   = ESPERA;
                        posicao_d  = comando;
                        contador_d = dist_dois ? CARGA_180 : CARGA_90;
                    end
                end
            end
            ESPERA: begin
                if (contador_q == '0) begin
                    estado_d = FIM;
                end else begin
                    contador_d = contador_q - 1'b1;
                end
            end
            FIM:     estado_d = OCIOSO;
            ERRO:    estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase
    end

    // State registers; reset aborts any move and re-centres the servo.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            posicao_q  <= NEUTRO;
            contador_q <= '0;
        end else begin
            estado_q   <= estado_d;
            posicao_q  <= posicao_d;
            contador_q <= contador_d;
        end
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        ocupado    = (estado_q == ESPERA);
        pronto     = (estado_q == FIM);
        erro       = (estado_q == ERRO);
        posicao    = posicao_q;
        db_posicao = posicao_q;
        db_estado  = estado_q;
    end

endmodule
